fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the five-stage MIPS pipeline. It drives the `pc_next`, `npc_on` and `stop` inputs of the fetch stage, and the IF/ID and ID/EX flush controls. It arbitrates between sequential fetch, D-stage branch/jump redirects, exception entry and `eret` return. It also generates stalls for load-use hazards and for a multi-cycle mult/div unit, whose busy counter it owns.

---
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the five-stage MIPS pipeline.
// Chooses between sequential fetch, D-stage branch/jump redirects,
// exception entry and eret return, and raises stalls for load-use hazards
// and for the multi-cycle mult/div unit, whose busy counter lives here.
//
// Handshake note: there is no valid/ready pairing on this block. Every
// request is a single-cycle level that is acted on in the cycle it is seen.
// The redirect (npc_on/pc_next) is combinational, so IF loads the target at
// the next rising edge. A stall lasts exactly as long as its cause.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          MULT_CYC   = 5,
  parameter int          DIV_CYC    = 10
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active low
  input  logic        hz_stall,
  input  logic        md_use,
  input  logic        md_start,
  input  logic        md_div,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_next,
  output logic        npc_on,
  output logic        stop,
  output logic        flush_d,
  output logic        flush_e,
  output logic        md_busy,
  output logic [1:0]  dbg_state   // current sequencer state, for checkers
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLUSHED = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_busy_q, md_busy_d;

  // Stall cause: a load-use hazard, or a HI/LO consumer in D while the
  // unit is busy or is being started by the instruction in E right now.
  logic stall;
  assign stall = hz_stall | (md_use & (md_busy_q | md_start));

  // State, counter and busy-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  // Mult/div busy counter: loads only when idle, otherwise counts down.
  // It is independent of the fetch state, so a flush never cuts HI/LO short.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start && !md_busy_q) begin
      cnt_d = md_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    md_busy_d = (cnt_d != 4'd0);
  end

  // Next-state and output decode, with the redirect priority resolved here.
  always_comb begin
    state_d = state_q;
    pc_next = 32'd0;
    npc_on  = 1'b0;
    stop    = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        // Single boot cycle: point IF at the reset vector, drain the pipe.
        pc_next = RESET_PC;
        npc_on  = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (exc_req) begin
          pc_next = EXC_VECTOR;
          npc_on  = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          state_d = ST_FLUSHED;
        end else if (eret_req) begin
          pc_next = epc;
          npc_on  = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          state_d = ST_FLUSHED;
        end else if (stall) begin
          // The frozen D instruction re-presents any branch later, so the
          // branch request is dropped for now and a bubble goes to E.
          stop    = 1'b1;
          flush_e = 1'b1;
        end else if (br_req) begin
          // Delay slot is already in IF and is kept: no flush.
          pc_next = br_target;
          npc_on  = 1'b1;
        end
      end

      ST_FLUSHED: begin
        // D holds a bubble, so its branch/hazard/HI-LO signals mean nothing.
        if (exc_req) begin
          pc_next = EXC_VECTOR;
          npc_on  = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (eret_req) begin
          pc_next = epc;
          npc_on  = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: recover through the boot sequence.
        state_d = ST_BOOT;
      end
    endcase
  end

  assign md_busy   = md_busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cases for reset, redirects, the mult/div
// stall and async reset, followed by randomized traffic checked cycle by
// cycle against a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  localparam int W = 37;  // {pc_next, npc_on, stop, flush_d, flush_e, md_busy}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        hz_stall, md_use, md_start, md_div, br_req, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc_next;
  logic        npc_on, stop, flush_d, flush_e, md_busy;
  logic [1:0]  dbg_state;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .hz_stall  (hz_stall),
    .md_use    (md_use),
    .md_start  (md_start),
    .md_div    (md_div),
    .br_req    (br_req),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .pc_next   (pc_next),
    .npc_on    (npc_on),
    .stop      (stop),
    .flush_d   (flush_d),
    .flush_e   (flush_e),
    .md_busy   (md_busy),
    .dbg_state (dbg_state)
  );

  logic [W-1:0] obs;
  assign obs = {pc_next, npc_on, stop, flush_d, flush_e, md_busy};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // booting: first cycle after reset; after_redirect: D holds a bubble.
  bit booting;
  bit after_redirect;
  int md_left;  // cycles remaining on the mult/div unit

  function automatic logic [W-1:0] pack(input logic [31:0] pc, input bit on,
                                        input bit st, input bit fd, input bit fe);
    return {pc, on, st, fd, fe, (md_left > 0)};
  endfunction

  function automatic logic [W-1:0] model_out();
    bit waiting;
    waiting = hz_stall || (md_use && (md_left > 0 || md_start));
    if (booting)            return pack(32'h0000_3000, 1, 0, 1, 1);
    if (exc_req)            return pack(32'h0000_4180, 1, 0, 1, 1);
    if (eret_req)           return pack(epc, 1, 0, 1, 1);
    if (after_redirect)     return pack(32'd0, 0, 0, 0, 0);
    if (waiting)            return pack(32'd0, 0, 1, 0, 1);
    if (br_req)             return pack(br_target, 1, 0, 0, 0);
    return pack(32'd0, 0, 0, 0, 0);
  endfunction

  task automatic model_edge();
    if (!reset) begin
      booting = 1; after_redirect = 0; md_left = 0;
      return;
    end
    if (booting) after_redirect = 0;
    else after_redirect = exc_req || eret_req;
    booting = 0;
    if (md_start && md_left == 0) md_left = md_div ? 10 : 5;
    else if (md_left > 0) md_left = md_left - 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    hz_stall = 0; md_use = 0; md_start = 0; md_div = 0;
    br_req = 0; br_target = 32'd0; exc_req = 0; eret_req = 0; epc = 32'd0;
  endtask

  task automatic drive_random();
    hz_stall  = ($urandom_range(0, 3) == 0);
    md_use    = ($urandom_range(0, 2) == 0);
    md_start  = booting ? 1'b0 : ($urandom_range(0, 5) == 0);
    md_div    = $urandom_range(0, 1) != 0;
    br_req    = ($urandom_range(0, 2) == 0);
    br_target = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    exc_req   = ($urandom_range(0, 15) == 0);
    eret_req  = ($urandom_range(0, 15) == 0);
    epc       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
  endtask

  // Called just after a falling edge with inputs already driven: compare,
  // then advance the model across the rising edge.
  task automatic step(input string tag);
    exp_q.push_back(model_out());
    #2;
    check(tag, obs, exp_q.pop_front());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  int stop_cnt, busy_cnt;

  initial begin
    reset = 0;
    drive_idle();
    booting = 1; after_redirect = 0; md_left = 0;
    @(negedge clk);
    step("in_reset0");
    step("in_reset1");

    // Reset release: one BOOT cycle, then RUN idle.
    reset = 1;
    #1;
    check("boot_pc",  W'(pc_next), W'(32'h3000));
    check("boot_ctl", W'({npc_on, stop, flush_d, flush_e}), W'(4'b1011));
    step("boot");
    #1;
    check("run_npc", W'(npc_on), W'(0));
    step("run_idle");

    // Branch in RUN: same-cycle redirect, no flush.
    br_req = 1; br_target = 32'h3040;
    #1;
    check("br_pc",  W'(pc_next), W'(32'h3040));
    check("br_ctl", W'({npc_on, stop, flush_d}), W'(3'b100));
    step("br");
    drive_idle();

    // div followed by a held HI/LO consumer, with a spurious restart.
    stop_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      md_use   = 1;
      md_start = (i == 0) || (i == 4);
      md_div   = (i == 0);
      #1;
      stop_cnt += int'(stop);
      busy_cnt += int'(md_busy);
      step("div_stall");
    end
    check("div_stop_cycles", W'(stop_cnt), W'(11));
    check("div_busy_cycles", W'(busy_cnt), W'(10));
    drive_idle();

    // Exception with branch and hazard: only the exception is taken.
    exc_req = 1; br_req = 1; br_target = 32'h3100; hz_stall = 1;
    #1;
    check("exc_pc",  W'(pc_next), W'(32'h4180));
    check("exc_ctl", W'({npc_on, stop, flush_d, flush_e}), W'(4'b1011));
    step("exc");
    drive_idle();
    br_req = 1; br_target = 32'h3200;
    #1;
    check("flushed_no_br", W'({npc_on, pc_next}), W'(0));
    step("flushed_br");
    drive_idle();
    step("run_again");

    // eret, then an exception in the following FLUSHED cycle.
    eret_req = 1; epc = 32'h3010;
    #1;
    check("eret_pc", W'(pc_next), W'(32'h3010));
    step("eret");
    drive_idle();
    exc_req = 1;
    #1;
    check("flushed_exc_pc", W'(pc_next), W'(32'h4180));
    step("flushed_exc");
    drive_idle();
    step("flushed_idle");
    step("run_idle2");

    // Async reset mid-stall with the counter at 7.
    md_start = 1; md_div = 1;
    step("div_load");
    drive_idle();
    repeat (3) step("div_count");
    hz_stall = 1;
    #1;
    check("pre_rst_stop", W'(stop), W'(1));
    reset = 0;
    #1;
    check("async_rst_pc",  W'(pc_next), W'(32'h3000));
    check("async_rst_ctl", W'({npc_on, stop, flush_d, flush_e, md_busy}), W'(5'b10110));
    booting = 1; after_redirect = 0; md_left = 0;
    @(negedge clk);
    drive_idle();
    reset = 1;
    step("boot2");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
